// File: rtl/i2c_master_tx.sv
// Write-only I2C initiator: START, address+W, ACK, one DATA_W-bit word MSB first, ACK, STOP.
// Define I2C_CLK_STRETCH_EN to let a responder stretch SCL during the high half of a slot.
module i2c_master_tx #(
   parameter int CLK_DIV = 250,
   parameter int DATA_W  = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [6:0]        tx_addr,
   input  logic [DATA_W-1:0] tx_data,
   output logic              busy,
   output logic              done,
   output logic              ack_err,
   output logic [2:0]        state_out,
   inout  wire               i2c_sda,
   inout  wire               i2c_scl
);
   // state   | meaning
   // S_IDLE  | both lines released, waiting for start
   // S_START | q0-q1 lines high, q2-q3 SDA low with SCL high
   // S_ADDR  | 8 slots of {addr, W=0}
   // S_ACK1  | SDA released, responder ACK sampled
   // S_DATA  | DATA_W slots, MSB first
   // S_ACK2  | SDA released, responder ACK sampled
   // S_STOP  | SDA low under SCL low, SCL released, then SDA released
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_ADDR  = 3'd2,
      S_ACK1  = 3'd3,
      S_DATA  = 3'd4,
      S_ACK2  = 3'd5,
      S_STOP  = 3'd6
   } state_t;

   localparam int TW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam int BW = (DATA_W > 8) ? $clog2(DATA_W) : 3;
   localparam logic [TW-1:0] TC_LOAD  = TW'(CLK_DIV - 1);
   localparam logic [BW-1:0] ADDR_MSB = BW'(7);
   localparam logic [BW-1:0] DATA_MSB = BW'(DATA_W - 1);

   state_t              state_q, state_d;
   logic [TW-1:0]       tmr_q, tmr_d;
   logic [1:0]          qtr_q, qtr_d;
   logic [BW-1:0]       bit_q, bit_d;
   logic [6:0]          addr_q, addr_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                err_q, err_d;

   logic                sda_in;
   logic                stall;
   logic                tmr_tc;
   logic                slot_end;
   logic                scl_low;
   logic                sda_low;
   logic [7:0]          addr_byte;

   assign sda_in    = i2c_sda;
   assign addr_byte = {addr_q, 1'b0};
   assign tmr_tc    = (tmr_q == '0);

`ifdef I2C_CLK_STRETCH_EN
   logic scl_in;
   assign scl_in = i2c_scl;
   // SCL is released in q2/q3; reading it low there means the responder is stretching
   assign stall  = (state_q != S_IDLE) && qtr_q[1] && !scl_in;
`else
   assign stall  = 1'b0;
`endif

   assign slot_end = tmr_tc && (qtr_q == 2'd3) && !stall;

   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      qtr_d   = qtr_q;
      bit_d   = bit_q;
      addr_d  = addr_q;
      data_d  = data_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      err_d   = err_q;

      if (state_q != S_IDLE && !stall) begin
         if (tmr_tc) begin
            tmr_d = TC_LOAD;
            qtr_d = qtr_q + 2'd1;
         end else begin
            tmr_d = tmr_q - TW'(1);
         end
      end

      case (state_q)
         S_IDLE: begin
            // done_q blocks a start landing in the completion cycle
            if (start && !done_q) begin
               state_d = S_START;
               addr_d  = tx_addr;
               data_d  = tx_data;
               busy_d  = 1'b1;
               err_d   = 1'b0;
               tmr_d   = TC_LOAD;
               qtr_d   = 2'd0;
               bit_d   = ADDR_MSB;
            end
         end
         S_START: if (slot_end) state_d = S_ADDR;
         S_ADDR: begin
            if (slot_end) begin
               if (bit_q == '0) state_d = S_ACK1;
               else             bit_d   = bit_q - BW'(1);
            end
         end
         S_ACK1: begin
            if (slot_end) begin
               if (sda_in) begin
                  err_d   = 1'b1;
                  state_d = S_STOP;
               end else begin
                  state_d = S_DATA;
                  bit_d   = DATA_MSB;
               end
            end
         end
         S_DATA: begin
            if (slot_end) begin
               if (bit_q == '0) state_d = S_ACK2;
               else             bit_d   = bit_q - BW'(1);
            end
         end
         S_ACK2: begin
            if (slot_end) begin
               if (sda_in) err_d = 1'b1;
               state_d = S_STOP;
            end
         end
         S_STOP: begin
            if (slot_end) begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      scl_low = 1'b0;
      sda_low = 1'b0;
      case (state_q)
         S_START: sda_low = qtr_q[1];
         S_ADDR: begin
            scl_low = !qtr_q[1];
            sda_low = !addr_byte[bit_q[2:0]];
         end
         S_ACK1, S_ACK2: scl_low = !qtr_q[1];
         S_DATA: begin
            scl_low = !qtr_q[1];
            sda_low = !data_q[bit_q];
         end
         S_STOP: begin
            scl_low = !qtr_q[1];
            sda_low = (qtr_q != 2'd3);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         tmr_q   <= '0;
         qtr_q   <= '0;
         bit_q   <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
         qtr_q   <= qtr_d;
         bit_q   <= bit_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   // Line drives decode straight from flops so an async reset releases them at once
   assign i2c_scl   = scl_low ? 1'b0 : 1'bz;
   assign i2c_sda   = sda_low ? 1'b0 : 1'bz;
   assign busy      = busy_q;
   assign done      = done_q;
   assign ack_err   = err_q;
   assign state_out = state_q;

endmodule

// File: tb/tb_i2c_master_tx.sv
// Bench for i2c_master_tx: slot-timeline model checked every cycle plus a bus-level responder.
module tb_i2c_master_tx;
   localparam int C    = 4;
   localparam int DW   = 32;
   localparam int SLOT = 4 * C;
   localparam logic [6:0] RESP_ADDR = 7'h2A;
`ifdef I2C_CLK_STRETCH_EN
   localparam int STRETCH = 50;
`else
   localparam int STRETCH = 0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [6:0]    tx_addr = '0;
   logic [DW-1:0] tx_data = '0;
   logic          busy, done, ack_err;
   logic [2:0]    state_out;
   wire           i2c_sda, i2c_scl;
   logic          resp_sda_low = 1'b0;
   logic          resp_scl_hold = 1'b0;

   pullup (i2c_sda);
   pullup (i2c_scl);
   assign i2c_sda = resp_sda_low  ? 1'b0 : 1'bz;
   assign i2c_scl = resp_scl_hold ? 1'b0 : 1'bz;

   i2c_master_tx #(.CLK_DIV(C), .DATA_W(DW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .tx_addr(tx_addr), .tx_data(tx_data),
      .busy(busy), .done(done), .ack_err(ack_err), .state_out(state_out),
      .i2c_sda(i2c_sda), .i2c_scl(i2c_scl)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
      end
   endfunction

   // Expected pad drives and state at cycle t of a frame, from the slot/quarter timeline
   function automatic void expect_at(input int t, input logic nack, input logic [6:0] a,
                                     input logic [DW-1:0] d, output logic e_scl,
                                     output logic e_sda, output logic [2:0] e_st);
      int s, q;
      logic [7:0] abyte;
      abyte = {a, 1'b0};
      s = t / SLOT;
      q = (t / C) % 4;
      e_scl = (q >= 2);
      e_sda = 1'b1;
      e_st  = 3'd6;
      if (s == 0) begin
         e_st = 3'd1; e_scl = 1'b1; e_sda = (q < 2);
      end else if (s <= 8) begin
         e_st = 3'd2; e_sda = abyte[8 - s];
      end else if (s == 9) begin
         e_st = 3'd3;
      end else if (!nack && s <= 9 + DW) begin
         e_st = 3'd4; e_sda = d[DW - 1 - (s - 10)];
      end else if (!nack && s == 10 + DW) begin
         e_st = 3'd5;
      end else begin
         e_st = 3'd6; e_sda = (q == 3);
      end
   endfunction

   logic          start_e = 1'b0;
   logic [6:0]    addr_e = '0;
   logic [DW-1:0] data_e = '0;
   always @(posedge clk) begin
      start_e <= start;
      addr_e  <= tx_addr;
      data_e  <= tx_data;
   end

   logic          m_active = 1'b0, m_done = 1'b0, m_err = 1'b0, m_nack = 1'b0;
   logic          was_active, was_done, frz;
   int            m_t = 0, m_len = 0;
   logic [6:0]    m_addr = '0;
   logic [DW-1:0] m_data = '0;
   logic          e_scl, e_sda;
   logic [2:0]    e_st;
   logic          scl_now, sda_now;
   logic          p_scl = 1'b1, p_sda = 1'b1;
   int            rise_cnt = 0, done_cnt = 0, run_cnt = 0, busy_len = 0;

   logic          r_active = 1'b0, r_match = 1'b0;
   int            r_cnt = 0, last_bits = 0, hold_cnt = 0;
   logic [7:0]    r_addr = '0;
   logic [DW-1:0] r_word = '0, last_word = '0;

   always @(negedge clk) begin
      scl_now = i2c_scl;
      sda_now = i2c_sda;
      if (!rst_n) begin
         m_active = 1'b0; m_done = 1'b0; m_err = 1'b0; run_cnt = 0;
      end else begin
         was_active = m_active;
         was_done   = m_done;
         m_done     = 1'b0;
         if (was_active) begin
            frz = resp_scl_hold && (((m_t / C) % 4) >= 2);
            if (!frz) m_t++;
            if (m_nack && m_t >= 10 * SLOT) m_err = 1'b1;
            if (m_t == m_len) begin
               m_active = 1'b0;
               m_done   = 1'b1;
            end
         end else if (start_e && !was_done) begin
            m_active = 1'b1; m_t = 0; m_addr = addr_e; m_data = data_e; m_err = 1'b0;
            m_nack   = (addr_e != RESP_ADDR);
            m_len    = (m_nack ? 11 : DW + 12) * SLOT;
         end
      end

      if (m_active) expect_at(m_t, m_nack, m_addr, m_data, e_scl, e_sda, e_st);
      else begin
         e_scl = 1'b1; e_sda = 1'b1; e_st = 3'd0;
      end
      chk("state_out", 32'(state_out), 32'(e_st));
      chk("busy", 32'(busy), 32'(m_active));
      chk("done", 32'(done), 32'(m_done));
      chk("ack_err", 32'(ack_err), 32'(m_err));
      chk("scl_line", 32'(scl_now), 32'(e_scl & ~resp_scl_hold));
      chk("sda_line", 32'(sda_now), 32'(e_sda & ~resp_sda_low));

      if (rst_n && p_scl && scl_now)
         chk("sda_stable_scl_high", 32'(p_sda != sda_now && e_st != 3'd1 && e_st != 3'd6), 32'd0);
      if (rst_n && !p_scl && scl_now) rise_cnt++;
      if (busy) run_cnt++;
      if (done) begin
         busy_len = run_cnt; run_cnt = 0; done_cnt++;
      end

      // Bus-level responder at RESP_ADDR
      if (!rst_n) begin
         r_active = 1'b0; resp_sda_low = 1'b0; resp_scl_hold = 1'b0; hold_cnt = 0;
      end else begin
         if (hold_cnt > 0) begin
            hold_cnt--;
            if (hold_cnt == 0) resp_scl_hold = 1'b0;
         end
         if (p_scl && scl_now && p_sda && !sda_now) begin
            r_active = 1'b1; r_cnt = 0; r_addr = '0; r_word = '0; r_match = 1'b0;
         end else if (p_scl && scl_now && !p_sda && sda_now) begin
            if (r_active) begin
               last_word = r_word; last_bits = r_cnt;
            end
            r_active = 1'b0;
         end else if (r_active && !p_scl && scl_now) begin
            r_cnt++;
            if (r_cnt <= 8) r_addr = {r_addr[6:0], sda_now};
            else if (r_cnt >= 10 && r_cnt <= 9 + DW) r_word = {r_word[DW-2:0], sda_now};
         end else if (r_active && p_scl && !scl_now) begin
            if (r_cnt == 8) begin
               r_match = (r_addr == {RESP_ADDR, 1'b0});
               resp_sda_low = r_match;
               if (r_match && STRETCH > 0) begin
                  resp_scl_hold = 1'b1;
                  hold_cnt = 2 * C + STRETCH;
               end
            end else if (r_cnt == 9) resp_sda_low = 1'b0;
            else if (r_cnt == 9 + DW) resp_sda_low = r_match;
            else if (r_cnt == 10 + DW) resp_sda_low = 1'b0;
         end
      end
      p_scl = scl_now;
      p_sda = sda_now;
   end

   task automatic send(input logic [6:0] a, input logic [DW-1:0] d);
      @(negedge clk);
      start = 1'b1; tx_addr = a; tx_data = d;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while (!done && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (!done) chk("frame_timeout", 32'(done), 32'd1);
   endtask

   task automatic clear_counts();
      rise_cnt = 0; done_cnt = 0;
   endtask

   logic [6:0]    ra;
   logic [DW-1:0] rd;

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_ack_err", 32'(ack_err), 32'd0);
      chk("rst_state", 32'(state_out), 32'd0);
      chk("rst_sda", 32'(i2c_sda), 32'd1);
      chk("rst_scl", 32'(i2c_scl), 32'd1);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      clear_counts();
      send(7'h2A, 32'hDEADBEEF);
      wait_done(2000);
      repeat (3) @(negedge clk);
      chk("word_deadbeef", last_word, 32'hDEADBEEF);
      chk("ack_err_ok", 32'(ack_err), 32'd0);
      chk("busy_len", 32'(busy_len), 32'(704 + STRETCH));
      chk("scl_rises", 32'(rise_cnt), 32'd43);
      chk("resp_bits", 32'(last_bits), 32'd43);
      chk("done_count", 32'(done_cnt), 32'd1);

      clear_counts();
      send(7'h15, 32'hCAFEF00D);
      wait_done(2000);
      repeat (3) @(negedge clk);
      chk("nack_ack_err", 32'(ack_err), 32'd1);
      chk("nack_scl_rises", 32'(rise_cnt), 32'd10);
      chk("nack_resp_bits", 32'(last_bits), 32'd10);
      chk("nack_done_count", 32'(done_cnt), 32'd1);
      chk("nack_sda_rel", 32'(i2c_sda), 32'd1);
      chk("nack_scl_rel", 32'(i2c_scl), 32'd1);

      clear_counts();
      send(7'h2A, 32'hDEADBEEF);
      repeat (15 * SLOT + STRETCH) @(negedge clk);
      send(7'h2A, 32'h12345678);
      wait_done(2000);
      repeat (3) @(negedge clk);
      chk("busy_start_ignored_word", last_word, 32'hDEADBEEF);
      chk("busy_start_done_count", 32'(done_cnt), 32'd1);

      send(7'h2A, 32'hA5A50F0F);
      repeat (20 * SLOT + C + 1 + STRETCH) @(negedge clk);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("midrst_sda", 32'(i2c_sda), 32'd1);
      chk("midrst_scl", 32'(i2c_scl), 32'd1);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_state", 32'(state_out), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      rd = $urandom;
      send(7'h2A, rd);
      wait_done(2000);
      repeat (3) @(negedge clk);
      chk("post_rst_word", last_word, rd);
      chk("post_rst_ack_err", 32'(ack_err), 32'd0);

      send(7'h2A, 32'h0F1E2D3C);
      wait_done(2000);
      start = 1'b1; tx_addr = 7'h2A; tx_data = 32'h11111111;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      chk("start_on_done_ignored", 32'(busy), 32'd0);

      for (int i = 0; i < 6; i++) begin
         ra = ($urandom_range(0, 1) == 1) ? RESP_ADDR : 7'($urandom_range(0, 127));
         rd = $urandom;
         send(ra, rd);
         repeat ($urandom_range(20, 150)) @(negedge clk);
         if (busy) send(7'($urandom_range(0, 127)), $urandom);
         wait_done(2000);
         repeat (3) @(negedge clk);
         chk("rand_ack_err", 32'(ack_err), 32'(ra != RESP_ADDR));
         if (ra == RESP_ADDR) chk("rand_word", last_word, rd);
      end

      repeat (5) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1);
   end

endmodule
